// File: rtl/serial_fifo_scheduler_pkg.sv
// Shared definitions for the serial FIFO scheduler: mode bit positions
// reported by the serial controller, and the two scheduler state types.
package serial_fifo_scheduler_pkg;

  // Positions inside the controller's 2-bit mode word
  localparam int SERIAL_TX_IDLE_BIT   = 0;
  localparam int SERIAL_RX_READY_BIT  = 1;

  typedef logic [7:0] Byte_t;
  typedef logic [1:0] Serial_mode_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_ISSUE,
    T_GUARD
  } Tx_sched_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_CAP,
    R_GUARD
  } Rx_sched_state_t;

endpackage

// File: rtl/serial_fifo_scheduler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (dropped when full unless popping)
//   pop        : advance head (ignored when empty unless pushing)
//   full/empty : occupancy flags, count : occupancy 0..DEPTH
//   head       : entry at read pointer, valid while !empty
module serial_fifo_scheduler_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A simultaneous pop frees the slot a full-FIFO push lands in, and a
  // simultaneous push gives an empty-FIFO pop something to consume.
  assign do_push = push && (!full  || pop);
  assign do_pop  = pop  && (!empty || push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;   // wraps modulo DEPTH (power of two)
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: head is only consumed while !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/serial_fifo_scheduler.sv
// Buffered front end for the serial controller. The CPU pushes TX bytes and
// pops RX bytes through two FIFOs; a TX scheduler drains the TX FIFO into the
// controller with write_op pulses, an RX scheduler pulls ready bytes into the
// RX FIFO with read_op pulses. Guard periods after each op give the
// controller time to update its registered mode bits.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cpu_wr_en/cpu_wr_data      : TX FIFO push;  tx_full, tx_count, tx_drop
//   cpu_rd_en/cpu_rd_data      : RX FIFO pop (FWFT head, 0 when empty);
//                                rx_empty, rx_count, rx_overrun
//   status_clr                 : clears both sticky flags
//   ser_write_op/ser_wdata     : byte issue to controller
//   ser_read_op/ser_rdata      : byte fetch from controller
//   ser_mode                   : [0] controller tx idle, [1] rx byte ready
module serial_fifo_scheduler
  import serial_fifo_scheduler_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TX_GUARD = 3,
  parameter int RX_GUARD = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_wr_en,
  input  logic [7:0]                  cpu_wr_data,
  input  logic                        cpu_rd_en,
  output logic [7:0]                  cpu_rd_data,
  output logic                        tx_full,
  output logic                        rx_empty,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        tx_drop,
  output logic                        rx_overrun,
  input  logic                        status_clr,
  output logic                        ser_write_op,
  output logic                        ser_read_op,
  input  logic [1:0]                  ser_mode,
  output logic [7:0]                  ser_wdata,
  input  logic [7:0]                  ser_rdata
);
  localparam int TGW = $clog2(TX_GUARD + 1);
  localparam int RGW = $clog2(RX_GUARD + 1);

  Tx_sched_state_t tx_state, tx_next;
  Rx_sched_state_t rx_state, rx_next;
  logic [TGW-1:0]  tx_gcnt, tx_gcnt_next;
  logic [RGW-1:0]  rx_gcnt, rx_gcnt_next;

  logic  tx_empty, tx_pop, wdata_load;
  Byte_t tx_head;
  logic  rx_full, rx_push;
  Byte_t rx_head;

  serial_fifo_scheduler_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cpu_wr_en),
    .pop   (tx_pop),
    .din   (cpu_wr_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  serial_fifo_scheduler_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (cpu_rd_en),
    .din   (ser_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  assign cpu_rd_data = rx_empty ? 8'h00 : rx_head;

  // Op strobes come straight off the state flops.
  assign ser_write_op = (tx_state == T_ISSUE);
  assign ser_read_op  = (rx_state == R_REQ);
  // Controller latched the byte at the R_REQ edge; it is stable during R_CAP.
  assign rx_push      = (rx_state == R_CAP);

  // ---------------- TX scheduler ----------------
  always_comb begin
    tx_next      = tx_state;
    tx_gcnt_next = tx_gcnt;
    tx_pop       = 1'b0;
    wdata_load   = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty && ser_mode[SERIAL_TX_IDLE_BIT]) begin
          tx_next    = T_ISSUE;
          wdata_load = 1'b1;   // wdata valid for the whole write_op cycle
        end
      end
      T_ISSUE: begin
        tx_pop       = 1'b1;
        tx_next      = T_GUARD;
        tx_gcnt_next = TGW'(TX_GUARD);
      end
      T_GUARD: begin
        if (tx_gcnt <= TGW'(1)) tx_next = T_IDLE;
        else                    tx_gcnt_next = tx_gcnt - 1'b1;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= T_IDLE;
      tx_gcnt   <= '0;
      ser_wdata <= '0;
    end else begin
      tx_state <= tx_next;
      tx_gcnt  <= tx_gcnt_next;
      if (wdata_load) ser_wdata <= tx_head;
    end
  end

  // ---------------- RX scheduler ----------------
  always_comb begin
    rx_next      = rx_state;
    rx_gcnt_next = rx_gcnt;
    case (rx_state)
      R_IDLE:  if (ser_mode[SERIAL_RX_READY_BIT] && !rx_full) rx_next = R_REQ;
      R_REQ:   rx_next = R_CAP;
      R_CAP: begin
        rx_next      = R_GUARD;
        rx_gcnt_next = RGW'(RX_GUARD);
      end
      R_GUARD: begin
        // Hold off until the controller's clear has dropped mode[1].
        if (rx_gcnt <= RGW'(1)) rx_next = R_IDLE;
        else                    rx_gcnt_next = rx_gcnt - 1'b1;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      rx_gcnt  <= '0;
    end else begin
      rx_state <= rx_next;
      rx_gcnt  <= rx_gcnt_next;
    end
  end

  // ---------------- sticky status ----------------
  // A push into a full TX FIFO is only lost if the scheduler is not popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (status_clr)                             tx_drop <= 1'b0;
      else if (cpu_wr_en && tx_full && !tx_pop)   tx_drop <= 1'b1;

      if (status_clr)                             rx_overrun <= 1'b0;
      else if (ser_mode[SERIAL_RX_READY_BIT] && rx_full && rx_state == R_IDLE)
                                                  rx_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_fifo_scheduler.sv
module tb_serial_fifo_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_wr_en, cpu_rd_en, status_clr;
  logic [7:0] cpu_wr_data, cpu_rd_data, ser_wdata, ser_rdata;
  logic       tx_full, rx_empty, tx_drop, rx_overrun;
  logic [4:0] tx_count, rx_count;
  logic       ser_write_op, ser_read_op;
  logic [1:0] ser_mode;

  always #5 clk = ~clk;

  serial_fifo_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_rd_en    (cpu_rd_en),
    .cpu_rd_data  (cpu_rd_data),
    .tx_full      (tx_full),
    .rx_empty     (rx_empty),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .tx_drop      (tx_drop),
    .rx_overrun   (rx_overrun),
    .status_clr   (status_clr),
    .ser_write_op (ser_write_op),
    .ser_read_op  (ser_read_op),
    .ser_mode     (ser_mode),
    .ser_wdata    (ser_wdata),
    .ser_rdata    (ser_rdata)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       full;
    logic       drop;
  } tx_vec_t;

  tx_vec_t    tv [18];
  logic [7:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wop(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (ser_write_op) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_rop(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (ser_read_op) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic pop_rx;
    cpu_rd_en = 1'b1;
    step();
    cpu_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         npulse, last, extra, k;
    logic [7:0] expd;

    rst_n = 1'b0; cpu_wr_en = 0; cpu_wr_data = 0; cpu_rd_en = 0;
    status_clr = 0; ser_mode = 2'b00; ser_rdata = 8'h00;
    repeat (2) step();

    // ---- reset state ----
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_flags", {tx_drop, rx_overrun}, 0);
    check("rst_ops", {ser_write_op, ser_read_op}, 0);
    check("rst_wdata", ser_wdata, 0);
    check("rst_rd_data", cpu_rd_data, 0);
    rst_n = 1'b1;
    step();

    // ---- TX drain of three bytes ----
    for (int i = 0; i < 3; i++) begin
      cpu_wr_en = 1'b1; cpu_wr_data = 8'h41 + 8'(i); step();
    end
    cpu_wr_en = 1'b0;
    check("tx_count_3", tx_count, 3);
    ser_mode = 2'b01; npulse = 0; last = -100;
    for (int c = 0; c < 40; c++) begin
      step();
      if (ser_write_op) begin
        check("tx_wdata_order", ser_wdata, 8'h41 + 8'(npulse));
        if (npulse > 0) check("tx_pulse_spacing_ge4", 32'((c - last) >= 4), 1);
        last = c; npulse++;
      end
    end
    check("tx_pulses", npulse, 3);
    check("tx_count_0", tx_count, 0);
    check("tx_wdata_hold", ser_wdata, 8'h43);
    ser_mode = 2'b00;

    // ---- TX fill / drop / clear table ----
    for (int i = 0; i < 17; i++)
      tv[i] = '{wr: 1'b1, d: 8'(i), clr: 1'b0, cnt: (i < 16) ? i + 1 : 16,
                full: (i >= 15), drop: (i == 16)};
    tv[17] = '{wr: 1'b0, d: 8'h00, clr: 1'b1, cnt: 16, full: 1'b1, drop: 1'b0};
    for (int i = 0; i < 18; i++) begin
      cpu_wr_en = tv[i].wr; cpu_wr_data = tv[i].d; status_clr = tv[i].clr;
      step();
      check($sformatf("tbl%0d_count", i), tx_count, tv[i].cnt);
      check($sformatf("tbl%0d_full", i), tx_full, tv[i].full);
      check($sformatf("tbl%0d_drop", i), tx_drop, tv[i].drop);
    end
    cpu_wr_en = 1'b0; status_clr = 1'b0;

    // ---- push into full TX while scheduler pops ----
    ser_mode = 2'b01;
    wait_wop(ok);
    check("tx_full_issue_seen", ok, 1);
    check("tx_full_first_wdata", ser_wdata, 8'h00);
    cpu_wr_en = 1'b1; cpu_wr_data = 8'hEE; step(); cpu_wr_en = 1'b0;
    check("tx_full_pushpop_count", tx_count, 16);
    check("tx_full_pushpop_nodrop", tx_drop, 0);
    npulse = 0;
    for (int c = 0; c < 200 && npulse < 16; c++) begin
      step();
      if (ser_write_op) begin
        expd = (npulse < 15) ? 8'(npulse + 1) : 8'hEE;
        check("tx_full_drain_order", ser_wdata, expd);
        npulse++;
      end
    end
    check("tx_full_drain_pulses", npulse, 16);
    step();
    check("tx_full_drain_count", tx_count, 0);
    ser_mode = 2'b00;

    // ---- RX single byte ----
    ser_rdata = 8'h5A; ser_mode = 2'b10;
    wait_rop(ok);
    check("rx_req_seen", ok, 1);
    ser_mode = 2'b00;
    extra = 0;
    for (int c = 0; c < 8; c++) begin step(); if (ser_read_op) extra++; end
    check("rx_single_extra_ops", extra, 0);
    check("rx_single_count", rx_count, 1);
    check("rx_single_data", cpu_rd_data, 8'h5A);
    pop_rx();
    check("rx_single_empty", rx_empty, 1);
    check("rx_single_rd_zero", cpu_rd_data, 0);

    // ---- RX fill to full, overrun ----
    ser_mode = 2'b10; k = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (ser_read_op) begin
        ser_rdata = 8'h10 + 8'(k); q.push_back(ser_rdata); k++;
      end
      if (rx_count == 16) break;
    end
    check("rx_fill_count", rx_count, 16);
    check("rx_fill_ops", k, 16);
    extra = 0;
    for (int c = 0; c < 10; c++) begin step(); if (ser_read_op) extra++; end
    check("rx_full_no_op", extra, 0);
    check("rx_overrun_set", rx_overrun, 1);
    status_clr = 1'b1; step(); status_clr = 1'b0;
    check("rx_overrun_clr_priority", rx_overrun, 0);
    step();
    check("rx_overrun_reset", rx_overrun, 1);

    check("rx_head_before_pop", cpu_rd_data, q[0]);
    pop_rx(); void'(q.pop_front());
    wait_rop(ok);
    check("rx_refill_req", ok, 1);
    ser_rdata = 8'h30; q.push_back(ser_rdata);
    extra = 0;
    for (int c = 0; c < 8; c++) begin step(); if (ser_read_op) extra++; end
    check("rx_refill_extra_ops", extra, 0);
    check("rx_refill_count", rx_count, 16);

    // ---- CPU pop in the same cycle as capture ----
    check("rx_head2", cpu_rd_data, q[0]);
    pop_rx(); void'(q.pop_front());
    wait_rop(ok);
    check("rx_cap_req", ok, 1);
    ser_rdata = 8'h31; q.push_back(ser_rdata);
    step();                       // now in capture cycle
    check("rx_cap_head", cpu_rd_data, q[0]);
    cpu_rd_en = 1'b1; ser_mode = 2'b00;
    step();
    cpu_rd_en = 1'b0; void'(q.pop_front());
    check("rx_cap_pop_count", rx_count, 15);

    for (int c = 0; c < 20; c++) begin
      if (rx_empty) break;
      check("rx_drain_order", cpu_rd_data, q.pop_front());
      pop_rx();
    end
    check("rx_drain_empty", rx_empty, 1);
    check("rx_drain_count", rx_count, 0);
    check("rx_drain_left", q.size(), 0);

    // ---- reset in T_GUARD ----
    ser_mode = 2'b01;
    cpu_wr_en = 1'b1; cpu_wr_data = 8'h77; step();
    cpu_wr_data = 8'h78; step(); cpu_wr_en = 1'b0;
    wait_wop(ok);
    check("rst_tx_issue_seen", ok, 1);
    step();                       // in guard, one byte still queued
    rst_n = 1'b0; #1;
    check("rst_guard_wdata", ser_wdata, 0);
    check("rst_guard_tx_count", tx_count, 0);
    check("rst_guard_wop", ser_write_op, 0);
    check("rst_guard_overrun", rx_overrun, 0);
    step(); rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin step(); if (ser_write_op) extra++; end
    check("rst_guard_no_stray", extra, 0);

    // ---- reset in R_CAP ----
    ser_mode = 2'b10; ser_rdata = 8'h99;
    wait_rop(ok);
    check("rst_rx_req_seen", ok, 1);
    step();                       // capture cycle
    rst_n = 1'b0; #1;
    check("rst_cap_rop", ser_read_op, 0);
    check("rst_cap_rx_count", rx_count, 0);
    check("rst_cap_rd_data", cpu_rd_data, 0);
    ser_mode = 2'b00;
    step(); rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin step(); if (ser_read_op) extra++; end
    check("rst_cap_no_stray", extra, 0);
    check("rst_cap_still_empty", rx_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
